nms_stage: RTL and testbench

NMS_STAGE -- requirements
Module: nms_stage

---
 rtl/nms_pkg.sv | 16 +
 rtl/nms_line_buffer.sv | 24 ++
 rtl/nms_stage.sv | 206 ++++++++++++++++++++
 tb/tb_nms_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nms_pkg.sv
// Shared definitions for the non-maximum suppression stage: direction codes
// and the sequencing state encoding.
package nms_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } nms_state_e;

   localparam logic [1:0] ANG_H     = 2'd0;  // horizontal gradient: compare W/E
   localparam logic [1:0] ANG_NE_SW = 2'd1;
   localparam logic [1:0] ANG_V     = 2'd2;  // vertical gradient: compare N/S
   localparam logic [1:0] ANG_NW_SE = 2'd3;

endpackage

// File: rtl/nms_line_buffer.sv
// One row of pixel storage addressed by column: the entry read at a column is
// the one written there a full row earlier, and is replaced in the same shift.
module nms_line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 13
) (
   input  logic                       clk,
   input  logic                       shift_en,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rd_data = mem_q[addr];

   always_ff @(posedge clk) begin
      if (shift_en) begin
         mem_q[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/nms_stage.sv
// Streaming 3x3 non-maximum suppression on Sobel magnitude/direction pixels.
// Each window shift emits the pixel one row and one column behind the input.
module nms_stage
   import nms_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int MAG_W      = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [MAG_W-1:0] in_mag,
   input  logic [1:0]       in_angle,
   output logic             out_valid,
   output logic [MAG_W-1:0] out_mag,
   output logic [1:0]       out_angle,
   output logic             out_eof,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT + 2);
   localparam int PW = MAG_W + 2;
   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_FLUSH_END = RW'(IMG_HEIGHT + 1);

   nms_state_e       state_q, state_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [PW-1:0]    win_q [3][3];
   logic [PW-1:0]    win_d [3][3];
   logic             win_vld_q, win_vld_d;
   logic             win_border_q, win_border_d;
   logic             win_eof_q, win_eof_d;
   logic             out_valid_q, out_valid_d;
   logic [MAG_W-1:0] out_mag_q, out_mag_d;
   logic [1:0]       out_angle_q, out_angle_d;
   logic             out_eof_q, out_eof_d;

   logic             shift;
   logic [PW-1:0]    pix;
   logic [PW-1:0]    a_rd, b_rd;
   logic [CW-1:0]    cen_col;
   logic [RW-1:0]    cen_row;
   logic             cen_ok;
   logic [MAG_W-1:0] center, nb_a, nb_b;
   logic [1:0]       cen_ang;

   assign out_valid = out_valid_q;
   assign out_mag   = out_mag_q;
   assign out_angle = out_angle_q;
   assign out_eof   = out_eof_q;
   assign dbg_state = state_q;

   // Handshake: a pixel transfers on a rising edge where in_valid && in_ready.
   // FLUSH ignores the input and injects zero pixels to drain the last row.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      in_ready = 1'b1;
      shift    = 1'b0;
      pix      = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_sof) begin
               shift   = 1'b1;
               pix     = {in_angle, in_mag};
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               shift = 1'b1;
               pix   = {in_angle, in_mag};
               if (row_q == ROW_LAST && col_q == COL_LAST) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            in_ready = 1'b0;
            shift    = 1'b1;
            if (row_q == ROW_FLUSH_END) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (shift) begin
         if (state_q == ST_FLUSH && row_q == ROW_FLUSH_END) begin
            col_d = '0;
            row_d = '0;
         end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   nms_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_lb_a (
      .clk(clk), .shift_en(shift), .addr(col_q), .wr_data(pix), .rd_data(a_rd)
   );

   nms_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_lb_b (
      .clk(clk), .shift_en(shift), .addr(col_q), .wr_data(a_rd), .rd_data(b_rd)
   );

   // The window centre trails the incoming pixel by IMG_WIDTH+1 in raster
   // order, so a column-0 input places the centre at the previous row's end.
   always_comb begin
      win_d        = win_q;
      win_border_d = win_border_q;
      win_eof_d    = win_eof_q;
      cen_col      = (col_q == '0) ? COL_LAST : col_q - CW'(1);
      cen_row      = (col_q == '0) ? row_q - RW'(2) : row_q - RW'(1);
      cen_ok       = (row_q >= RW'(2)) || (row_q == RW'(1) && col_q != '0);
      win_vld_d    = shift && cen_ok;
      if (shift) begin
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = win_q[i][1];
            win_d[i][1] = win_q[i][2];
         end
         win_d[0][2]  = b_rd;
         win_d[1][2]  = a_rd;
         win_d[2][2]  = pix;
         win_border_d = (cen_row == '0) || (cen_row == ROW_LAST) ||
                        (cen_col == '0) || (cen_col == COL_LAST);
         win_eof_d    = (row_q == ROW_FLUSH_END);
      end
   end

   always_comb begin
      center  = win_q[1][1][MAG_W-1:0];
      cen_ang = win_q[1][1][PW-1:MAG_W];
      nb_a    = win_q[1][0][MAG_W-1:0];
      nb_b    = win_q[1][2][MAG_W-1:0];
      unique case (cen_ang)
         ANG_H: begin
            nb_a = win_q[1][0][MAG_W-1:0];
            nb_b = win_q[1][2][MAG_W-1:0];
         end
         ANG_NE_SW: begin
            nb_a = win_q[0][2][MAG_W-1:0];
            nb_b = win_q[2][0][MAG_W-1:0];
         end
         ANG_V: begin
            nb_a = win_q[0][1][MAG_W-1:0];
            nb_b = win_q[2][1][MAG_W-1:0];
         end
         ANG_NW_SE: begin
            nb_a = win_q[0][0][MAG_W-1:0];
            nb_b = win_q[2][2][MAG_W-1:0];
         end
         default: ;
      endcase
      out_valid_d = win_vld_q;
      out_mag_d   = out_mag_q;
      out_angle_d = out_angle_q;
      out_eof_d   = 1'b0;
      if (win_vld_q) begin
         out_mag_d   = (!win_border_q && center >= nb_a && center > nb_b) ? center : '0;
         out_angle_d = cen_ang;
         out_eof_d   = win_eof_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_vld_q    <= 1'b0;
         win_border_q <= 1'b0;
         win_eof_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_mag_q    <= '0;
         out_angle_q  <= '0;
         out_eof_q    <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_vld_q    <= win_vld_d;
         win_border_q <= win_border_d;
         win_eof_q    <= win_eof_d;
         out_valid_q  <= out_valid_d;
         out_mag_q    <= out_mag_d;
         out_angle_q  <= out_angle_d;
         out_eof_q    <= out_eof_d;
         win_q        <= win_d;
      end
   end

endmodule

// File: tb/tb_nms_stage.sv
// Randomised scoreboard bench for nms_stage on an 8x6 frame with a
// frame-level reference model of the suppression rules.
module tb_nms_stage;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int MW = 11;
   localparam int N  = W * H;
   localparam int EW = MW + 3;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sof   = 1'b0;
   logic [MW-1:0] in_mag   = '0;
   logic [1:0]    in_angle = '0;
   logic          in_ready;
   logic          out_valid;
   logic [MW-1:0] out_mag;
   logic [1:0]    out_angle;
   logic          out_eof;
   logic [1:0]    dbg_state;

   nms_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(MW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sof(in_sof), .in_mag(in_mag), .in_angle(in_angle),
      .out_valid(out_valid), .out_mag(out_mag), .out_angle(out_angle),
      .out_eof(out_eof), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   logic [EW-1:0] exp_q[$];
   int checks    = 0;
   int passes    = 0;
   int outs_seen = 0;
   int fm[N];
   int fa[N];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
   endtask

   function automatic int px(input int r, input int c);
      return fm[r * W + c];
   endfunction

   // Expected output for every pixel of the frame held in fm/fa, raster order.
   task automatic push_frame(input int limit);
      int n = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int cen, ang, a, b, m, val;
            bit eof;
            cen = px(r, c);
            ang = fa[r * W + c];
            eof = (r == H - 1) && (c == W - 1);
            m   = 0;
            if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
               case (ang)
                  0:       begin a = px(r, c - 1);     b = px(r, c + 1);     end
                  1:       begin a = px(r - 1, c + 1); b = px(r + 1, c - 1); end
                  2:       begin a = px(r - 1, c);     b = px(r + 1, c);     end
                  default: begin a = px(r - 1, c - 1); b = px(r + 1, c + 1); end
               endcase
               if (cen >= a && cen > b) m = cen;
            end
            val = (int'(eof) << (MW + 2)) | (ang << MW) | m;
            if (n < limit) exp_q.push_back(val[EW-1:0]);
            n++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         outs_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output: got mag=%0d ang=%0d eof=%0d expected none", out_mag, out_angle, out_eof);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("out_pixel", int'({out_eof, out_angle, out_mag}), int'(e));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_pixel(input int mag, input int ang, input bit sof);
      bit ok;
      int guard = 0;
      in_valid = 1'b1;
      in_mag   = MW'(mag);
      in_angle = 2'(ang);
      in_sof   = sof;
      do begin
         ok = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!ok && guard < 100);
      if (!ok) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   // gap_mode: 0 back-to-back, 1 in_valid every other cycle, 2 random gaps
   task automatic run_frame(input int gap_mode);
      int n = 0;
      push_frame(N);
      for (int i = 0; i < N; i++) begin
         if (i > 0 && gap_mode == 1) idle(1);
         if (gap_mode == 2) idle($urandom_range(0, 2));
         drive_pixel(fm[i], fa[i], i == 0);
      end
      while (!in_ready && n < 50) begin
         n++;
         idle(1);
      end
      check("flush_ready_low_cycles", n, W + 1);
      idle(3);
      check("frame_drained", exp_q.size(), 0);
   endtask

   task automatic fill_uniform(input int m, input int a);
      for (int i = 0; i < N; i++) begin
         fm[i] = m;
         fa[i] = a;
      end
   endtask

   task automatic fill_random(input int max_mag);
      for (int i = 0; i < N; i++) begin
         fm[i] = $urandom_range(0, max_mag);
         fa[i] = $urandom_range(0, 3);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_out_mag"}, int'(out_mag), 0);
      check({tag, "_out_angle"}, int'(out_angle), 0);
      check({tag, "_out_eof"}, int'(out_eof), 0);
      check({tag, "_in_ready"}, int'(in_ready), 1);
      check({tag, "_state"}, int'(dbg_state), 0);
   endtask

   initial begin
      int seen;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      fill_uniform(100, 0);
      run_frame(0);

      fill_uniform(10, 2);
      fm[2 * W + 3] = 500;
      run_frame(0);

      fill_uniform(10, 0);
      fa[3 * W + 4] = 1;
      fm[3 * W + 4] = 200;
      fm[2 * W + 5] = 200;
      fm[4 * W + 3] = 50;
      run_frame(0);
      fm[2 * W + 5] = 50;
      fm[4 * W + 3] = 200;
      run_frame(0);

      fill_random(2047);
      run_frame(0);
      run_frame(1);
      fill_random(7);
      run_frame(0);
      run_frame(1);
      fill_random(2047);
      run_frame(2);

      // stray pixels ahead of the start of frame must be dropped
      for (int i = 0; i < 5; i++) drive_pixel($urandom_range(0, 2047), $urandom_range(0, 3), 1'b0);
      fill_random(15);
      run_frame(0);

      // reset after 20 pixels abandons the frame
      fill_random(2047);
      push_frame(20 - (W + 1));
      for (int i = 0; i < 20; i++) drive_pixel(fm[i], fa[i], i == 0);
      idle(2);
      check("partial_frame_drained", exp_q.size(), 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      seen = outs_seen;
      for (int i = 20; i < 30; i++) drive_pixel(fm[i], fa[i], 1'b0);
      idle(W + 4);
      check("no_output_after_reset", outs_seen - seen, 0);
      check("idle_after_reset", int'(dbg_state), 0);

      fill_random(2047);
      run_frame(2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
      $fatal(1, "watchdog");
   end

endmodule
